// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the pipelined single-precision multiplier.
package fp_mul_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Normalised operation handed from stage 2 to the rounding stage
    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        logic [23:0]       mant;
        logic              guard;
        logic              sticky;
        fp_class_e         cls;
        rmode_e            mode;
    } s2_payload_t;

    // Encodings above RMM are reserved and behave as round-to-nearest-even
    function automatic rmode_e decode_rmode(input logic [2:0] m);
        return (m > 3'd4) ? RNE : rmode_e'(m);
    endfunction

    // Subnormals are deliberately folded into ZERO (flush-to-zero inputs)
    function automatic fp_class_e classify(input logic [7:0] e, input logic [22:0] f);
        if (e == 8'h00)
            return ZERO;
        else if (e == 8'hFF)
            return (f != 23'd0) ? NAN : INF;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding, overflow/underflow resolution and IEEE packing.
module fp_round
    import fp_mul_pkg::*;
#(
    parameter logic [31:0] QNAN_VAL = 32'h7FC00000
) (
    input  s2_payload_t p,
    output logic [31:0] z,
    output logic        ovrf,
    output logic        udrf
);

    localparam logic signed [9:0] EXP_OVF = 10'sd255;
    localparam logic signed [9:0] EXP_UNF = 10'sd0;

    logic              inexact;
    logic              round_up;
    logic              to_inf;
    logic [24:0]       sum;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;

    // Round the 24-bit significand, then resolve the final encoding and flags
    always_comb begin
        inexact  = p.guard | p.sticky;
        round_up = 1'b0;
        to_inf   = 1'b1;
        z        = 32'd0;
        ovrf     = 1'b0;
        udrf     = 1'b0;

        case (p.mode)
            RTZ:     round_up = 1'b0;
            RDN:     round_up = p.sign & inexact;
            RUP:     round_up = ~p.sign & inexact;
            RMM:     round_up = p.guard;
            default: round_up = p.guard & (p.sticky | p.mant[0]);
        endcase

        // Whether an overflow saturates to infinity or to the largest finite value
        case (p.mode)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = p.sign;
            RUP:     to_inf = ~p.sign;
            default: to_inf = 1'b1;
        endcase

        sum = {1'b0, p.mant} + {24'd0, round_up};
        // A carry out means the significand rolled over to 1.000..0
        if (sum[24]) begin
            frac_r = sum[23:1];
            exp_r  = p.exp + 10'sd1;
        end else begin
            frac_r = sum[22:0];
            exp_r  = p.exp;
        end

        case (p.cls)
            NAN: begin
                z    = QNAN_VAL;
                ovrf = 1'b1;
            end
            INF: begin
                z    = {p.sign, 8'hFF, 23'd0};
                ovrf = 1'b1;
            end
            ZERO: begin
                z    = {p.sign, 31'd0};
                udrf = 1'b1;
            end
            default: begin
                if (exp_r >= EXP_OVF) begin
                    z    = to_inf ? {p.sign, 8'hFF, 23'd0} : {p.sign, MAX_FINITE};
                    ovrf = 1'b1;
                end else if (exp_r <= EXP_UNF) begin
                    z    = {p.sign, 31'd0};
                    udrf = 1'b1;
                end else begin
                    z    = {p.sign, exp_r[7:0], frac_r};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 single-precision multiplier:
// unpack/multiply -> normalise -> round/pack, one operation per cycle.
module fp_mul_pipe #(
    parameter int          EXP_W = 8,
    parameter int          MAN_W = 23,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic        out_valid,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);
    import fp_mul_pkg::*;

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;

    // ---------------- stage 1: unpack, classify, multiply ----------------
    logic [31:0]       op       [2];
    logic [EXP_W-1:0]  op_exp   [2];
    logic [MAN_W-1:0]  op_man   [2];
    logic [SIG_W-1:0]  op_sig   [2];
    fp_class_e         op_cls   [2];

    assign op[0] = fp_X;
    assign op[1] = fp_Y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign op_exp[gi] = op[gi][30:23];
            assign op_man[gi] = op[gi][22:0];
            assign op_sig[gi] = {1'b1, op_man[gi]};
            assign op_cls[gi] = classify(op_exp[gi], op_man[gi]);
        end
    endgenerate

    fp_class_e          s1_cls_next;
    logic [PROD_W-1:0]  s1_prod_next;
    logic signed [9:0]  s1_exp_next;

    // Combine operand classes; NaN and inf*0 dominate, then inf, then zero
    always_comb begin
        s1_cls_next = NORM;
        if (op_cls[0] == NAN || op_cls[1] == NAN ||
            (op_cls[0] == INF && op_cls[1] == ZERO) ||
            (op_cls[0] == ZERO && op_cls[1] == INF))
            s1_cls_next = NAN;
        else if (op_cls[0] == INF || op_cls[1] == INF)
            s1_cls_next = INF;
        else if (op_cls[0] == ZERO || op_cls[1] == ZERO)
            s1_cls_next = ZERO;
    end

    assign s1_prod_next = PROD_W'(op_sig[0]) * PROD_W'(op_sig[1]);
    assign s1_exp_next  = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]})
                        - 10'(EXP_BIAS);

    logic               s1_valid_reg;
    logic               s1_sign_reg;
    logic signed [9:0]  s1_exp_reg;
    logic [PROD_W-1:0]  s1_prod_reg;
    fp_class_e          s1_cls_reg;
    rmode_e             s1_mode_reg;

    // Stage-1 valid, cleared by reset so in-flight work is dropped
    always_ff @(posedge clk) begin
        if (rst)
            s1_valid_reg <= 1'b0;
        else
            s1_valid_reg <= in_valid;
    end

    // Stage-1 datapath; the rounding mode is captured alongside the operands
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_sign_reg <= fp_X[31] ^ fp_Y[31];
            s1_exp_reg  <= s1_exp_next;
            s1_prod_reg <= s1_prod_next;
            s1_cls_reg  <= s1_cls_next;
            s1_mode_reg <= decode_rmode(r_mode);
        end
    end

    // ---------------- stage 2: normalise ----------------
    s2_payload_t s2_next;
    s2_payload_t s2_reg;
    logic        s2_valid_reg;

    // Product of two [1,2) significands lies in [1,4); bring it back to [1,2)
    always_comb begin
        s2_next.sign = s1_sign_reg;
        s2_next.cls  = s1_cls_reg;
        s2_next.mode = s1_mode_reg;
        if (s1_prod_reg[PROD_W-1]) begin
            s2_next.exp    = s1_exp_reg + 10'sd1;
            s2_next.mant   = s1_prod_reg[47:24];
            s2_next.guard  = s1_prod_reg[23];
            s2_next.sticky = |s1_prod_reg[22:0];
        end else begin
            s2_next.exp    = s1_exp_reg;
            s2_next.mant   = s1_prod_reg[46:23];
            s2_next.guard  = s1_prod_reg[22];
            s2_next.sticky = |s1_prod_reg[21:0];
        end
    end

    // Stage-2 valid
    always_ff @(posedge clk) begin
        if (rst)
            s2_valid_reg <= 1'b0;
        else
            s2_valid_reg <= s1_valid_reg;
    end

    // Stage-2 payload
    always_ff @(posedge clk) begin
        if (s1_valid_reg)
            s2_reg <= s2_next;
    end

    // ---------------- stage 3: round and pack ----------------
    logic [31:0] rnd_z;
    logic        rnd_ovrf;
    logic        rnd_udrf;

    fp_round #(
        .QNAN_VAL (QNAN)
    ) u_round (
        .p    (s2_reg),
        .z    (rnd_z),
        .ovrf (rnd_ovrf),
        .udrf (rnd_udrf)
    );

    logic        out_valid_reg;
    logic [31:0] fp_z_reg;
    logic        ovrf_reg;
    logic        udrf_reg;

    // Output register; results hold between valids, reset value keeps udrf consistent with a zero exponent
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            fp_z_reg      <= 32'd0;
            ovrf_reg      <= 1'b0;
            udrf_reg      <= 1'b1;
        end else begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                fp_z_reg <= rnd_z;
                ovrf_reg <= rnd_ovrf;
                udrf_reg <= rnd_udrf;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign fp_Z      = fp_z_reg;
    assign ovrf      = ovrf_reg;
    assign udrf      = udrf_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: stimulus pushes expected results from an
// arithmetic reference model, a monitor pops and compares on each out_valid.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  r_mode;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic        out_valid;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .r_mode    (r_mode),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .out_valid (out_valid),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [31:0] z;
        logic        ov;
        logic        ud;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference: exact integer product of significands, rounded by comparing
    // the discarded remainder against one half ulp.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] m);
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        logic        s;
        bit          nx, ny, ix, iy, zx, zy, up, inf_ok;
        longint unsigned sig, q, rem, half;
        int k, sh, e, mm;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        s  = x[31] ^ y[31];
        nx = (ex == 8'hFF) && (fx != 0);
        ny = (ey == 8'hFF) && (fy != 0);
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        zx = (ex == 8'h00);
        zy = (ey == 8'h00);
        if (nx || ny || (ix && zy) || (iy && zx)) return {2'b10, 32'h7FC00000};
        if (ix || iy) return {2'b10, s, 8'hFF, 23'd0};
        if (zx || zy) return {2'b01, s, 31'd0};
        mm   = (m > 3'd4) ? 0 : int'(m);
        sig  = longint'({1'b1, fx}) * longint'({1'b1, fy});
        k    = (sig >= (64'd1 << 47)) ? 47 : 46;
        sh   = k - 23;
        q    = sig >> sh;
        rem  = sig - (q << sh);
        half = 64'd1 << (sh - 1);
        e    = int'(ex) + int'(ey) - 127 + (k - 46);
        case (mm)
            0:       up = (rem > half) || ((rem == half) && q[0]);
            1:       up = 1'b0;
            2:       up = s && (rem != 0);
            3:       up = !s && (rem != 0);
            default: up = (rem >= half);
        endcase
        if (up) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            inf_ok = (mm == 0) || (mm == 4) || ((mm == 2) && s) || ((mm == 3) && !s);
            return inf_ok ? {2'b10, s, 8'hFF, 23'd0} : {2'b10, s, 31'h7F7FFFFF};
        end
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          r;
        logic [7:0]  e;
        logic [31:0] f;
        r = $urandom_range(0, 15);
        f = $urandom;
        case (r)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 0; end
            2:       e = 8'($urandom_range(1, 40));
            3:       e = 8'($urandom_range(215, 254));
            4:       begin e = 8'($urandom_range(100, 150)); f = 32'h007FFFFF; end
            default: e = 8'($urandom_range(64, 190));
        endcase
        return {1'($urandom_range(0, 1)), e, f[22:0]};
    endfunction

    // Drive one operation for one cycle and record its expected result
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        exp_t        e;
        logic [33:0] r;
        r     = model(x, y, m);
        e.x   = x; e.y = y; e.m = m;
        e.z   = r[31:0];
        e.ov  = r[33];
        e.ud  = r[32];
        e.due = cyc + 3;
        sb.push_back(e);
        fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        n_vec++;
        if (out_valid !== 1'b0 || fp_Z !== 32'd0 || ovrf !== 1'b0 || udrf !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got valid=%b z=%h ov=%b ud=%b, want valid=0 z=00000000 ov=0 ud=1",
                     tag, out_valid, fp_Z, ovrf, udrf);
        end else
            $display("ok   %s: reset outputs", tag);
    endtask

    // Monitor: pop and compare on each output; check hold otherwise
    exp_t        mon_e;
    logic [31:0] last_z;
    logic        last_ov, last_ud;
    bit          armed = 0;

    always @(negedge clk) begin
        if (rst) begin
            last_z  = 32'd0;
            last_ov = 1'b0;
            last_ud = 1'b1;
            armed   = 1;
        end else if (out_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got z=%h at cyc %0d, want no out_valid", fp_Z, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (fp_Z !== mon_e.z || ovrf !== mon_e.ov || udrf !== mon_e.ud || cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL result x=%h y=%h m=%0d: got z=%h ov=%b ud=%b cyc=%0d, want z=%h ov=%b ud=%b cyc=%0d",
                             mon_e.x, mon_e.y, mon_e.m, fp_Z, ovrf, udrf, cyc,
                             mon_e.z, mon_e.ov, mon_e.ud, mon_e.due);
                end else
                    $display("ok   x=%h y=%h m=%0d -> z=%h ov=%b ud=%b",
                             mon_e.x, mon_e.y, mon_e.m, fp_Z, ovrf, udrf);
                last_z  = mon_e.z;
                last_ov = mon_e.ov;
                last_ud = mon_e.ud;
            end
        end else if (armed) begin
            if (fp_Z !== last_z || ovrf !== last_ov || udrf !== last_ud) begin
                n_vec++;
                n_fail++;
                $display("FAIL hold: got z=%h ov=%b ud=%b, want z=%h ov=%b ud=%b",
                         fp_Z, ovrf, udrf, last_z, last_ov, last_ud);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; r_mode = 3'd0; fp_X = 32'd0; fp_Y = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst = 1'b0;
        idle(2);

        // Directed cases
        issue(32'h40000000, 32'h40400000, 3'd0);
        idle(4);
        issue(32'h3F800001, 32'h3F800001, 3'd0);
        issue(32'h3F800001, 32'h3F800001, 3'd1);
        issue(32'h3F800001, 32'h3F800001, 3'd3);
        issue(32'h7F000000, 32'h7F000000, 3'd0);
        issue(32'h7F000000, 32'h7F000000, 3'd1);
        issue(32'hFF000000, 32'h7F000000, 3'd2);
        issue(32'h7F000000, 32'h7F000000, 3'd2);
        issue(32'hFF000000, 32'h7F000000, 3'd3);
        issue(32'hFF000000, 32'h7F000000, 3'd4);
        issue(32'h00800000, 32'h00800000, 3'd3);
        issue(32'h80000000, 32'h3F800000, 3'd0);
        issue(32'h7FC00000, 32'h3F800000, 3'd0);
        issue(32'h7F800000, 32'h00000000, 3'd1);
        issue(32'hFF800000, 32'h3F800000, 3'd0);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF, 3'd4);
        issue(32'h3F800001, 32'h3F800001, 3'd6);
        idle(5);

        // Ten back-to-back random operations
        for (int i = 0; i < 10; i++)
            issue(rand_op(), rand_op(), 3'($urandom_range(0, 7)));
        idle(5);

        // Random stream with occasional gaps
        for (int i = 0; i < 300; i++) begin
            issue(rand_op(), rand_op(), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

        // Reset with two operations in flight: both must vanish
        issue(32'h40000000, 32'h40400000, 3'd0);
        issue(32'h3F800001, 32'h3F800001, 3'd3);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check_reset("reset_midstream");
        @(posedge clk); #1;
        check_reset("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_valid: got out_valid=%b, want 0", out_valid);
            end
            @(posedge clk); #1;
        end
        issue(32'h40400000, 32'h40400000, 3'd0);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, want 0", sb.size());
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Pipelined IEEE-754 single-precision multiplier. It is the result-producing end of the dut_if protocol: it consumes fp_X, fp_Y and r_mode, and produces fp_Z, ovrf and udrf.
- Fully pipelined: accepts one operation per cycle, no backpressure, fixed latency of 3 cycles.
- Output flag semantics match the bench's interface assertions:
  - fp_Z exponent field all-zeros implies udrf=1.
  - fp_Z exponent field all-ones implies ovrf=1.

Parameters:
- EXP_W, 8, exponent field width. Only 8 is verified.
- MAN_W, 23, fraction field width. Only 23 is verified.
- QNAN, 32'h7FC00000, canonical NaN emitted for every NaN result.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode valid this cycle.
- r_mode  in  3  rounding mode.
- fp_X  in  32  operand A.
- fp_Y  in  32  operand B.
- out_valid  out  1  fp_Z, ovrf and udrf carry a new result.
- fp_Z  out  32  product.
- ovrf  out  1  overflow / special-high flag.
- udrf  out  1  underflow / zero flag.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all stage valids; out_valid=0.
  - fp_Z=0, ovrf=0, udrf=1. This keeps the exponent-zero implies udrf rule true during reset.
  - Reset mid-stream discards all in-flight operations. The first out_valid comes 3 cycles after the first in_valid following reset release.
- Latency and hold:
  - in_valid in cycle N produces out_valid in cycle N+3 with its result.
  - Back-to-back inputs give back-to-back outputs in order.
  - When out_valid=0, fp_Z, ovrf and udrf hold their last values.
- Stage 1, unpack and classify:
  - Classify each operand as zero, normal, inf or NaN.
  - Subnormal inputs are treated as signed zero.
  - Sign = sX ^ sY.
  - 24x24 significand multiply to 48 bits.
  - Biased exponent eX+eY-127, computed 10-bit signed.
- Stage 2, normalize:
  - If product bit 47 is set, shift right 1 and increment the exponent.
  - Form the 24-bit mantissa, guard bit and sticky bit (OR of the remaining low bits).
- Stage 3, round and pack (sub-module fp_round):
  - r_mode 000 RNE: ties to even.
  - r_mode 001 RTZ.
  - r_mode 010 RDN: toward -inf.
  - r_mode 011 RUP: toward +inf.
  - r_mode 100 RMM: ties away from zero.
  - r_mode 101..111: treated as RNE.
  - Mantissa carry-out on rounding increments the exponent; re-check overflow after rounding.
- Overflow (final exponent >= 255):
  - RNE and RMM give ±inf.
  - RTZ gives ±0x7F7FFFFF magnitude.
  - RDN gives +max finite or -inf; RUP gives +inf or -max finite.
  - ovrf=1 in all overflow cases.
- Underflow (final exponent <= 0): flush to signed zero in every mode; udrf=1.
- Special cases:
  - Any NaN operand, or inf*0, gives QNAN with ovrf=1.
  - inf*finite-nonzero or inf*inf gives ±inf with ovrf=1.
  - zero*finite gives signed zero with udrf=1.
- Flags:
  - ovrf=1 iff the fp_Z exponent field is all-ones, or on rounded overflow to max finite.
  - udrf=1 iff the fp_Z exponent field is zero.
  - ovrf and udrf are never both 1.
- Mode capture: r_mode is captured with the operands and travels down the pipeline. A change mid-stream affects only newly issued operations.

Decomposition:
- fp_mul_pkg holds:
  - rmode_e enum (RNE, RTZ, RDN, RUP, RMM).
  - fp_class_e enum (ZERO, NORM, INF, NAN).
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN, MAX_FINITE=31'h7F7FFFFF.
  - Packed struct for stage-2 to stage-3 payload: sign, exp, mant, guard, sticky, class, mode.
- One sub-module, fp_round: combinational rounding, overflow/underflow resolution and packing, instantiated in stage 3.

Test Plan:
- 0x40000000 * 0x40400000, RNE -> 3 cycles later out_valid=1, fp_Z=0x40C00000, ovrf=0, udrf=0.
- 0x3F800001 * 0x3F800001:
  - RNE -> 0x3F800002.
  - RTZ -> 0x3F800002.
  - RUP -> 0x3F800003.
  - All with flags 0.
- 0x7F000000 * 0x7F000000:
  - RNE -> 0x7F800000, ovrf=1.
  - RTZ -> 0x7F7FFFFF, ovrf=1.
  - Same operands with fp_X=0xFF000000 under RDN -> 0xFF800000.
- 0x00800000 * 0x00800000, any mode -> 0x00000000, udrf=1. Also 0x80000000 * 0x3F800000 -> 0x80000000, udrf=1.
- Specials:
  - 0x7FC00000 * 0x3F800000 -> 0x7FC00000, ovrf=1.
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, ovrf=1.
- Pipeline and reset:
  - 10 back-to-back random valids -> 10 in-order results at a 3-cycle offset.
  - Assert rst with 2 operations in flight -> no out_valid for them, fp_Z=0, udrf=1, ovrf=0.
